// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter performing one single-bit LSL/LSR/ASR/ROL step per clock
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dout_q, step_d;
  logic             carry_q, step_c_d, busy_q, done_q;
  // one single-bit step of the working register for the captured mode
  always_comb begin
    step_d = mode_q == 2'b00 ? {dout_q[WIDTH-2:0], 1'b0} :
             mode_q == 2'b01 ? {1'b0, dout_q[WIDTH-1:1]} :
             mode_q == 2'b10 ? {dout_q[WIDTH-1], dout_q[WIDTH-1:1]} :
                               {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
    step_c_d = (mode_q[0] ^ mode_q[1]) ? dout_q[0] : dout_q[WIDTH-1];
  end
  // control FSM with registered outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dout_q  <= din;
          mode_q  <= mode;
          cnt_q   <= amount;
          carry_q <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= amount == '0;
          state_q <= amount == '0 ? DONE : SHIFT;
        end
        SHIFT: begin
          dout_q  <= step_d;
          carry_q <= step_c_d;
          cnt_q   <= cnt_q - AMT_W'(1);
          done_q  <= cnt_q == AMT_W'(1);
          state_q <= cnt_q == AMT_W'(1) ? DONE : SHIFT;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign dout  = dout_q;
  assign carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed checking of seq_shifter against a closed-form model
module tb_seq_shifter;
  localparam int W = 8;
  localparam int AW = $clog2(W) + 1;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] amount = '0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          carry, busy, done;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            chk_en = 1'b0;
  seq_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
    .din(din), .dout(dout), .carry(carry), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  // result after k steps, in closed form: {carry, value}
  function automatic logic [W:0] f(logic [W-1:0] d, logic [1:0] m, int k);
    logic [127:0] x, y;
    logic signed [127:0] s, s2;
    logic [W-1:0] v;
    logic c;
    int r;
    x = {{(128-W){1'b0}}, d};
    s = signed'({{(128-W){d[W-1]}}, d});
    if (k == 0) return {1'b0, d};
    case (m)
      2'd0: begin y = x << k; v = y[W-1:0]; c = y[W]; end
      2'd1: begin y = (x << 1) >> k; c = y[0]; y = x >> k; v = y[W-1:0]; end
      2'd2: begin s2 = (s <<< 1) >>> k; c = s2[0]; s2 = s >>> k; v = s2[W-1:0]; end
      default: begin r = k % W; y = (x << r) | (x >> (W - r)); v = y[W-1:0]; c = v[0]; end
    endcase
    return {c, v};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: 0 idle, 1 shifting, 2 done
  int         ph = 0, k = 0, tot = 0;
  logic [1:0] m_mode = '0;
  logic [W-1:0] m_din = '0, e_dout = '0;
  logic       e_carry = 1'b0;
  logic [W:0] t;
  always @(posedge clk) begin
    if (rst) begin
      ph = 0; e_dout = '0; e_carry = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        m_din = din; m_mode = mode; tot = int'(amount); k = 0;
        e_dout = din; e_carry = 1'b0;
        ph = tot == 0 ? 2 : 1;
      end
    end else if (ph == 1) begin
      k++;
      t = f(m_din, m_mode, k);
      e_dout = t[W-1:0]; e_carry = t[W];
      if (k == tot) ph = 2;
    end else ph = 0;
  end
  always @(negedge clk) if (chk_en) begin
    chk("dout", dout, e_dout);
    chk("carry", carry, e_carry);
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 2);
  end
  // start one operation, disturb inputs while busy, report latency and result
  task automatic run(logic [1:0] m, int a, logic [W-1:0] d, bit hold,
                     logic [W-1:0] xd, logic xc, int xcyc);
    int cyc;
    @(negedge clk);
    start = 1'b1; mode = m; amount = AW'(a); din = d;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 40) begin
      start = hold ? 1'b1 : 1'($urandom % 2);
      din = hold ? '0 : W'($urandom);
      mode = 2'($urandom); amount = AW'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, xcyc);
    chk("res_dout", dout, xd);
    chk("res_carry", carry, xc);
    chk("res_busy", busy, 1'b1);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_hold", dout, xd);
  endtask
  initial begin
    logic [W:0] p;
    p = f(8'h81, 2'd0, 1);  chk("model_lsl", p, 9'h102);
    p = f(8'h90, 2'd2, 3);  chk("model_asr", p, 9'h0F2);
    p = f(8'hA5, 2'd3, 8);  chk("model_rol", p, 9'h1A5);
    p = f(8'hFF, 2'd1, 8);  chk("model_lsr", p, 9'h100);
    p = f(8'h81, 2'd0, 12); chk("model_big", p, 9'h000);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    run(2'd0, 1, 8'h81, 0, 8'h02, 1'b1, 2);
    run(2'd3, 8, 8'hA5, 0, 8'hA5, 1'b1, 9);
    run(2'd1, 8, 8'hFF, 1, 8'h00, 1'b1, 9);
    run(2'd1, 0, 8'h3C, 0, 8'h3C, 1'b0, 1);
    run(2'd2, 12, 8'h80, 0, 8'hFF, 1'b1, 13);
    @(negedge clk);
    start = 1'b1; mode = 2'd2; amount = AW'(3); din = 8'h90;
    @(negedge clk);
    start = 1'b0; din = 8'h00;
    chk("asr_c1", dout, 8'h90);
    @(negedge clk); chk("asr_c2", dout, 8'hC8);
    @(negedge clk); chk("asr_c3", dout, 8'hE4);
    @(negedge clk); chk("asr_c4", dout, 8'hF2);
    chk("asr_done", done, 1'b1);
    chk("asr_carry", carry, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 2'd3; amount = AW'(5); din = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_dout", dout, 0);
    chk("abort_busy", busy, 0);
    repeat (8) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    rst = 1'b1; start = 1'b1; amount = AW'(2); din = 8'hEE;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_dout", dout, 0);
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      mode = 2'($urandom); amount = AW'($urandom); din = W'($urandom);
      rst = ($urandom % 150) == 0;
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
